// File: rtl/fifo_flow_ctrl_if.sv
// rtl/fifo_flow_ctrl_if.sv - source/destination FIFO handshake bundle for fifo_flow_ctrl
interface fifo_flow_ctrl_if #(
    parameter int data_width = 6
);
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [data_width-1:0] vc0_data;
    logic [data_width-1:0] vc1_data;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  d0_full;
    logic                  d1_full;
    logic                  err_vc0;
    logic                  err_vc1;
    logic                  err_d0;
    logic                  err_d1;
    logic                  vc0_rd;
    logic                  vc1_rd;
    logic                  d0_wr;
    logic                  d1_wr;
    logic [data_width-1:0] d_data;

    // Controller side
    modport slave (
        input  vc0_empty, vc1_empty, vc0_data, vc1_data,
        input  d0_almost_full, d1_almost_full, d0_full, d1_full,
        input  err_vc0, err_vc1, err_d0, err_d1,
        output vc0_rd, vc1_rd, d0_wr, d1_wr, d_data
    );

    // FIFO bank side
    modport master (
        output vc0_empty, vc1_empty, vc0_data, vc1_data,
        output d0_almost_full, d1_almost_full, d0_full, d1_full,
        output err_vc0, err_vc1, err_d0, err_d1,
        input  vc0_rd, vc1_rd, d0_wr, d1_wr, d_data
    );
endinterface

// File: rtl/fifo_flow_ctrl.sv
// rtl/fifo_flow_ctrl.sv - transmit FIFO bank controller: VC0-priority pop, MSB routing, sticky error
module fifo_flow_ctrl #(
    parameter int data_width   = 6,
    parameter int umbral_width = 4
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [umbral_width-1:0] Umbral_VC_in,
    input  logic [umbral_width-1:0] Umbral_D_in,
    fifo_flow_ctrl_if.slave         fifo,
    output logic [umbral_width-1:0] Umbral_VC_out,
    output logic [umbral_width-1:0] Umbral_D_out,
    output logic                    fifo_init,
    output logic [2:0]              state,
    output logic                    idle,
    output logic                    active,
    output logic                    error
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                state_q;
    logic                  pend_vld;
    logic                  pend_src;
    logic                  any_err;
    logic                  dst_busy;
    logic                  pop_ok;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic [data_width-1:0] wdata;

    assign any_err  = fifo.err_vc0 | fifo.err_vc1 | fifo.err_d0 | fifo.err_d1;
    // Route is unknown until the word returns, so both destinations must have room
    assign dst_busy = fifo.d0_almost_full | fifo.d1_almost_full | fifo.d0_full | fifo.d1_full;
    assign pop_ok   = (state_q == S_ACTIVE) && !dst_busy;
    assign vc0_pop  = pop_ok && !fifo.vc0_empty;
    assign vc1_pop  = pop_ok && fifo.vc0_empty && !fifo.vc1_empty;

    assign wdata = pend_vld ? (pend_src ? fifo.vc1_data : fifo.vc0_data) : '0;

    assign fifo.vc0_rd = vc0_pop;
    assign fifo.vc1_rd = vc1_pop;
    assign fifo.d_data = wdata;
    assign fifo.d0_wr  = pend_vld && !wdata[data_width-1];
    assign fifo.d1_wr  = pend_vld && wdata[data_width-1];

    assign state  = state_q;
    assign idle   = (state_q == S_IDLE);
    assign active = (state_q == S_ACTIVE);
    assign error  = (state_q == S_ERROR);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= S_RESET;
            Umbral_VC_out <= '0;
            Umbral_D_out  <= '0;
            fifo_init     <= 1'b0;
            pend_vld      <= 1'b0;
            pend_src      <= 1'b0;
        end else begin
            pend_vld <= vc0_pop | vc1_pop;
            pend_src <= vc1_pop;
            case (state_q)
                S_RESET: begin
                    state_q   <= S_INIT;
                    fifo_init <= 1'b0;
                end
                S_INIT: begin
                    Umbral_VC_out <= Umbral_VC_in;
                    Umbral_D_out  <= Umbral_D_in;
                    if (!init) begin
                        state_q   <= S_IDLE;
                        fifo_init <= 1'b1;
                    end else begin
                        fifo_init <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (init) begin
                        state_q   <= S_INIT;
                        fifo_init <= 1'b0;
                    end else if (any_err) begin
                        state_q <= S_ERROR;
                    end else if (!fifo.vc0_empty || !fifo.vc1_empty) begin
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // A word popped this cycle is dropped when leaving for INIT/ERROR
                    if (init) begin
                        state_q   <= S_INIT;
                        fifo_init <= 1'b0;
                        pend_vld  <= 1'b0;
                    end else if (any_err) begin
                        state_q  <= S_ERROR;
                        pend_vld <= 1'b0;
                    end else if (fifo.vc0_empty && fifo.vc1_empty && !pend_vld) begin
                        state_q <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (init) begin
                        state_q   <= S_INIT;
                        fifo_init <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_RESET;
                    fifo_init <= 1'b0;
                    pend_vld  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// tb/tb_fifo_flow_ctrl.sv - directed self-checking bench for fifo_flow_ctrl
module tb_fifo_flow_ctrl;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_L;
    logic       init;
    logic [3:0] uvc_in, ud_in, uvc_out, ud_out;
    logic       fifo_init;
    logic [2:0] state;
    logic       idle, active, error;
    logic       d0_af, d1_af, d0_f, d1_f, e_vc0, e_vc1, e_d0, e_d1;

    int compared   = 0;
    int mismatched = 0;

    logic [5:0] mem0 [0:15];
    logic [5:0] mem1 [0:15];
    int         head0 = 0, tail0 = 0, head1 = 0, tail1 = 0;
    logic [5:0] vc0_data_r = '0;
    logic [5:0] vc1_data_r = '0;
    logic [5:0] log_d   [0:63];
    logic       log_dst [0:63];
    int         log_n = 0;

    fifo_flow_ctrl_if #(.data_width(6)) bus ();

    assign bus.vc0_empty      = (tail0 == head0);
    assign bus.vc1_empty      = (tail1 == head1);
    assign bus.vc0_data       = vc0_data_r;
    assign bus.vc1_data       = vc1_data_r;
    assign bus.d0_almost_full = d0_af;
    assign bus.d1_almost_full = d1_af;
    assign bus.d0_full        = d0_f;
    assign bus.d1_full        = d1_f;
    assign bus.err_vc0        = e_vc0;
    assign bus.err_vc1        = e_vc1;
    assign bus.err_d0         = e_d0;
    assign bus.err_d1         = e_d1;

    fifo_flow_ctrl #(.data_width(6), .umbral_width(4)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .Umbral_VC_in(uvc_in), .Umbral_D_in(ud_in), .fifo(bus),
        .Umbral_VC_out(uvc_out), .Umbral_D_out(ud_out), .fifo_init(fifo_init),
        .state(state), .idle(idle), .active(active), .error(error)
    );

    // Source FIFOs with registered read data, and a log of destination writes
    always @(posedge clk) begin
        if (bus.vc0_rd) begin
            vc0_data_r <= mem0[head0 % 16];
            head0      <= head0 + 1;
        end
        if (bus.vc1_rd) begin
            vc1_data_r <= mem1[head1 % 16];
            head1      <= head1 + 1;
        end
        if (bus.d0_wr || bus.d1_wr) begin
            log_d[log_n % 64]   <= bus.d_data;
            log_dst[log_n % 64] <= bus.d1_wr;
            log_n               <= log_n + 1;
        end
    end

    task push0(input logic [5:0] v);
        mem0[tail0 % 16] = v;
        tail0 = tail0 + 1;
    endtask

    task push1(input logic [5:0] v);
        mem1[tail1 % 16] = v;
        tail1 = tail1 + 1;
    endtask

    task test_reset;
        @(negedge clk);
        @(negedge clk);
        compared++; if (state !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", state); end
        compared++; if (fifo_init !== 1'b0) begin mismatched++; $display("FAIL reset_fifo_init: got %b expected 0", fifo_init); end
        compared++; if ({uvc_out, ud_out} !== 8'h00) begin mismatched++; $display("FAIL reset_umbral: got %h expected 00", {uvc_out, ud_out}); end
        compared++; if ({idle, active, error} !== 3'b000) begin mismatched++; $display("FAIL reset_decodes: got %b expected 000", {idle, active, error}); end
        compared++; if ({bus.vc0_rd, bus.vc1_rd, bus.d0_wr, bus.d1_wr} !== 4'b0000) begin mismatched++; $display("FAIL reset_strobes: got %b expected 0000", {bus.vc0_rd, bus.vc1_rd, bus.d0_wr, bus.d1_wr}); end
        compared++; if (bus.d_data !== 6'h00) begin mismatched++; $display("FAIL reset_d_data: got %h expected 00", bus.d_data); end
    endtask

    task test_config;
        reset_L = 1'b1; init = 1'b1; uvc_in = 4'd1; ud_in = 4'd2;
        @(negedge clk);
        compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL cfg_init_state: got %0d expected 1", state); end
        compared++; if (fifo_init !== 1'b0) begin mismatched++; $display("FAIL cfg_init_fifo_init: got %b expected 0", fifo_init); end
        @(negedge clk);
        compared++; if (uvc_out !== 4'd1) begin mismatched++; $display("FAIL cfg_umbral_vc: got %0d expected 1", uvc_out); end
        compared++; if (ud_out !== 4'd2) begin mismatched++; $display("FAIL cfg_umbral_d: got %0d expected 2", ud_out); end
        init = 1'b0;
        @(negedge clk);
        compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL cfg_idle_state: got %0d expected 2", state); end
        compared++; if ({idle, fifo_init} !== 2'b11) begin mismatched++; $display("FAIL cfg_idle_flags: got %b expected 11", {idle, fifo_init}); end
        uvc_in = 4'd7; ud_in = 4'd9;
        @(negedge clk);
        compared++; if ({uvc_out, ud_out} !== 8'h12) begin mismatched++; $display("FAIL cfg_umbral_hold: got %h expected 12", {uvc_out, ud_out}); end
        compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL cfg_idle_stay: got %0d expected 2", state); end
    endtask

    task test_vc0_route;
        push0(6'h05); push0(6'h25);
        @(negedge clk);
        compared++; if ({state, active} !== 4'b0111) begin mismatched++; $display("FAIL route_active: got %b expected 0111", {state, active}); end
        compared++; if ({bus.vc0_rd, bus.d0_wr, bus.d1_wr} !== 3'b100) begin mismatched++; $display("FAIL route_c0_strobes: got %b expected 100", {bus.vc0_rd, bus.d0_wr, bus.d1_wr}); end
        @(negedge clk);
        compared++; if ({bus.vc0_rd, bus.d0_wr, bus.d1_wr} !== 3'b110) begin mismatched++; $display("FAIL route_c1_strobes: got %b expected 110", {bus.vc0_rd, bus.d0_wr, bus.d1_wr}); end
        compared++; if (bus.d_data !== 6'h05) begin mismatched++; $display("FAIL route_c1_data: got %h expected 05", bus.d_data); end
        @(negedge clk);
        compared++; if ({bus.vc0_rd, bus.d0_wr, bus.d1_wr} !== 3'b001) begin mismatched++; $display("FAIL route_c2_strobes: got %b expected 001", {bus.vc0_rd, bus.d0_wr, bus.d1_wr}); end
        compared++; if (bus.d_data !== 6'h25) begin mismatched++; $display("FAIL route_c2_data: got %h expected 25", bus.d_data); end
        @(negedge clk);
        compared++; if ({state, bus.d0_wr, bus.d1_wr, bus.d_data} !== {3'd3, 2'b00, 6'h00}) begin mismatched++; $display("FAIL route_drain: got %h expected %h", {state, bus.d0_wr, bus.d1_wr, bus.d_data}, {3'd3, 2'b00, 6'h00}); end
        @(negedge clk);
        compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL route_back_idle: got %0d expected 2", state); end
    endtask

    task test_priority;
        logic [5:0] exp_d [0:4];
        logic [4:0] e_rd0, e_rd1, e_wr0, e_wr1;
        int         n;
        exp_d[0] = 6'h00; exp_d[1] = 6'h0A; exp_d[2] = 6'h0B; exp_d[3] = 6'h31; exp_d[4] = 6'h12;
        e_rd0 = 5'b00011; e_rd1 = 5'b01100; e_wr0 = 5'b10110; e_wr1 = 5'b01000;
        push0(6'h0A); push0(6'h0B); push1(6'h31); push1(6'h12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++; if ({bus.vc0_rd, bus.vc1_rd} !== {e_rd0[i], e_rd1[i]}) begin mismatched++; $display("FAIL prio_rd[%0d]: got %b expected %b", i, {bus.vc0_rd, bus.vc1_rd}, {e_rd0[i], e_rd1[i]}); end
            compared++; if ({bus.d0_wr, bus.d1_wr} !== {e_wr0[i], e_wr1[i]}) begin mismatched++; $display("FAIL prio_wr[%0d]: got %b expected %b", i, {bus.d0_wr, bus.d1_wr}, {e_wr0[i], e_wr1[i]}); end
            compared++; if (bus.d_data !== exp_d[i]) begin mismatched++; $display("FAIL prio_data[%0d]: got %h expected %h", i, bus.d_data, exp_d[i]); end
        end
        n = 0;
        while (state !== 3'd2 && n < 6) begin
            @(negedge clk);
            n++;
        end
        compared++; if (n !== 2) begin mismatched++; $display("FAIL prio_drain_cycles: got %0d expected 2", n); end
    endtask

    task test_backpressure;
        int base;
        int n;
        base = log_n;
        d1_af = 1'b1;
        push0(6'h21); push0(6'h03); push0(6'h3F);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if ({state, bus.vc0_rd, bus.vc1_rd} !== 5'b01100) begin mismatched++; $display("FAIL bp_hold[%0d]: got %b expected 01100", i, {state, bus.vc0_rd, bus.vc1_rd}); end
        end
        d1_af = 1'b0;
        #1;
        compared++; if (bus.vc0_rd !== 1'b1) begin mismatched++; $display("FAIL bp_resume: got %b expected 1", bus.vc0_rd); end
        @(negedge clk);
        compared++; if ({bus.d1_wr, bus.d_data} !== {1'b1, 6'h21}) begin mismatched++; $display("FAIL bp_first_write: got %h expected %h", {bus.d1_wr, bus.d_data}, {1'b1, 6'h21}); end
        d1_af = 1'b1;
        #1;
        compared++; if ({bus.vc0_rd, bus.d1_wr} !== 2'b01) begin mismatched++; $display("FAIL bp_mid_stall: got %b expected 01", {bus.vc0_rd, bus.d1_wr}); end
        @(negedge clk);
        compared++; if ({bus.vc0_rd, bus.d0_wr, bus.d1_wr} !== 3'b000) begin mismatched++; $display("FAIL bp_mid_quiet: got %b expected 000", {bus.vc0_rd, bus.d0_wr, bus.d1_wr}); end
        d1_af = 1'b0;
        n = 0;
        while (state !== 3'd2 && n < 12) begin
            @(negedge clk);
            n++;
        end
        compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL bp_drain_timeout: got state %0d expected 2", state); end
        compared++; if (log_n - base !== 3) begin mismatched++; $display("FAIL bp_write_count: got %0d expected 3", log_n - base); end
        compared++; if ({log_dst[base % 64], log_d[base % 64]} !== {1'b1, 6'h21}) begin mismatched++; $display("FAIL bp_word0: got %h expected %h", {log_dst[base % 64], log_d[base % 64]}, {1'b1, 6'h21}); end
        compared++; if ({log_dst[(base + 1) % 64], log_d[(base + 1) % 64]} !== {1'b0, 6'h03}) begin mismatched++; $display("FAIL bp_word1: got %h expected %h", {log_dst[(base + 1) % 64], log_d[(base + 1) % 64]}, {1'b0, 6'h03}); end
        compared++; if ({log_dst[(base + 2) % 64], log_d[(base + 2) % 64]} !== {1'b1, 6'h3F}) begin mismatched++; $display("FAIL bp_word2: got %h expected %h", {log_dst[(base + 2) % 64], log_d[(base + 2) % 64]}, {1'b1, 6'h3F}); end
    endtask

    task test_error;
        int base;
        base = log_n;
        push0(6'h07);
        @(negedge clk);
        compared++; if ({state, bus.vc0_rd} !== 4'b0111) begin mismatched++; $display("FAIL err_pop_state: got %b expected 0111", {state, bus.vc0_rd}); end
        e_d0 = 1'b1;
        @(negedge clk);
        compared++; if ({state, error, fifo_init} !== 5'b10011) begin mismatched++; $display("FAIL err_enter: got %b expected 10011", {state, error, fifo_init}); end
        compared++; if ({bus.d0_wr, bus.d1_wr, bus.d_data} !== 8'h00) begin mismatched++; $display("FAIL err_suppress: got %h expected 00", {bus.d0_wr, bus.d1_wr, bus.d_data}); end
        e_d0 = 1'b0;
        push0(6'h09);
        @(negedge clk);
        compared++; if ({state, error, bus.vc0_rd} !== 5'b10010) begin mismatched++; $display("FAIL err_sticky: got %b expected 10010", {state, error, bus.vc0_rd}); end
        init = 1'b1;
        @(negedge clk);
        compared++; if ({state, error, fifo_init} !== 5'b00100) begin mismatched++; $display("FAIL err_to_init: got %b expected 00100", {state, error, fifo_init}); end
        tail0 = head0;
        init  = 1'b0;
        @(negedge clk);
        compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL err_back_idle: got %0d expected 2", state); end
        compared++; if (log_n !== base) begin mismatched++; $display("FAIL err_no_write: got %0d writes expected 0", log_n - base); end
    endtask

    task test_async_reset;
        push0(6'h11); push0(6'h13);
        @(negedge clk);
        @(negedge clk);
        compared++; if ({bus.d0_wr, bus.d_data} !== {1'b1, 6'h11}) begin mismatched++; $display("FAIL arst_pre_write: got %h expected %h", {bus.d0_wr, bus.d_data}, {1'b1, 6'h11}); end
        #2 reset_L = 1'b0;
        #1;
        compared++; if ({state, idle, active, error, fifo_init} !== 7'b0) begin mismatched++; $display("FAIL arst_state: got %b expected 0000000", {state, idle, active, error, fifo_init}); end
        compared++; if ({bus.vc0_rd, bus.vc1_rd, bus.d0_wr, bus.d1_wr, bus.d_data} !== 10'h000) begin mismatched++; $display("FAIL arst_outputs: got %h expected 000", {bus.vc0_rd, bus.vc1_rd, bus.d0_wr, bus.d1_wr, bus.d_data}); end
        compared++; if ({uvc_out, ud_out} !== 8'h00) begin mismatched++; $display("FAIL arst_umbral: got %h expected 00", {uvc_out, ud_out}); end
        tail0 = head0;
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL arst_release: got %0d expected 1", state); end
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; uvc_in = 4'd0; ud_in = 4'd0;
        d0_af = 1'b0; d1_af = 1'b0; d0_f = 1'b0; d1_f = 1'b0;
        e_vc0 = 1'b0; e_vc1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
        test_reset;
        test_config;
        test_vc0_route;
        test_priority;
        test_backpressure;
        test_error;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
- Main-logic controller for the transmit-layer FIFO bank: two virtual-channel source FIFOs (VC0, VC1) and two destination FIFOs (D0, D1).
- Sequences reset, threshold configuration and FIFO init.
- Arbitrates pops from VC0/VC1 with VC0 strict priority, and routes each word to D0 or D1 by its MSB under almost-full backpressure.
- Reports the global state; sticky error on any FIFO overflow flag.

Parameters:
- data_width, 6, word width of all FIFOs
- umbral_width, 4, width of the threshold (Umbral) configuration fields

Ports:
- clk  in  1  clock, rising edge
- reset_L  in  1  reset, asynchronous, active-low
- init  in  1  1 = enter/hold configuration (INIT)
- Umbral_VC_in  in  umbral_width  threshold for VC FIFOs, latched in INIT
- Umbral_D_in  in  umbral_width  threshold for D FIFOs, latched in INIT
- vc0_empty, vc1_empty  in  1 each  source FIFO empty flags
- vc0_data, vc1_data  in  data_width each  source FIFO data_out (registered, valid the cycle after rd)
- d0_almost_full, d1_almost_full, d0_full, d1_full  in  1 each  destination flags
- err_vc0, err_vc1, err_d0, err_d1  in  1 each  FIFO error flags
- vc0_rd, vc1_rd  out  1 each  source read enables
- d0_wr, d1_wr  out  1 each  destination write enables
- d_data  out  data_width  write data to both D FIFOs
- Umbral_VC_out, Umbral_D_out  out  umbral_width each  latched thresholds to FIFOs
- fifo_init  out  1  0 = FIFOs held cleared, 1 = FIFOs run
- state  out  3  0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
- idle, active, error  out  1 each  state decodes

Behaviour:
- Reset: state=RESET. Umbral_*_out=0, fifo_init=0, pend_vld=0, pend_src=0. All combinational outputs derive from these, giving rd/wr strobes=0, d_data=0, idle=active=error=0.
- RESET -> INIT on first clock with reset_L=1.
- INIT:
  - fifo_init=0.
  - Umbral_*_out <= Umbral_*_in every cycle.
  - init=0 -> IDLE.
- IDLE:
  - fifo_init=1, idle=1.
  - init=1 -> INIT.
  - Otherwise any err_* -> ERROR.
  - Otherwise (!vc0_empty | !vc1_empty) -> ACTIVE.
- ACTIVE:
  - active=1, fifo_init=1.
  - Pop allowed when d0_almost_full, d1_almost_full, d0_full and d1_full are all 0.
  - vc0_rd = allowed & !vc0_empty.
  - vc1_rd = allowed & vc0_empty & !vc1_empty.
  - Read strobes are combinational; at most one pop per cycle.
  - Transitions, in priority order: init=1 -> INIT; any err_* -> ERROR; vc0_empty & vc1_empty & !pend_vld -> IDLE.
- Pending write:
  - pend_vld <= vc0_rd|vc1_rd; pend_src <= vc1_rd.
  - On the next cycle: d_data = pend_src ? vc1_data : vc0_data.
  - d0_wr = pend_vld & !d_data[data_width-1]; d1_wr = pend_vld & d_data[data_width-1].
  - Latency: pop at cycle t gives a destination write at t+1. Back-to-back pops give one write per cycle.
  - When pend_vld=0, d_data=0 and both write strobes are 0.
- ERROR:
  - error=1, fifo_init=1.
  - No rd/wr strobes; pend_vld cleared on entry.
  - Sticky: exits only via init=1 -> INIT, or reset.
- Entering INIT or ERROR: any pending write is suppressed (pend_vld <= 0).
- Asynchronous reset mid-operation: immediate return to reset values, including dropping an in-flight word.
- Backpressure is checked on both D FIFOs before the pop, because the route is unknown until the data returns. The almost_full margin covers the single in-flight word.
- Umbral_*_out holds its last latched value outside INIT.

Test Plan:
- Reset, then init=1 with Umbral_VC_in=1, Umbral_D_in=2, then init=0 -> state 0->1->2; Umbral_VC_out=1, Umbral_D_out=2; fifo_init rises in IDLE.
- VC0 holds 6'h05, 6'h25; VC1 empty -> ACTIVE; vc0_rd for 2 cycles; d0_wr with d_data=6'h05, then d1_wr with d_data=6'h25; returns to IDLE once the pipe drains.
- VC0 and VC1 both non-empty -> only vc0_rd until vc0_empty; vc1_rd asserts on the following cycle; never both in one cycle.
- d1_almost_full=1 with words pending -> vc*_rd=0 while it is high; pops resume the cycle after it falls; no lost or duplicated words.
- err_d0 pulse in ACTIVE with a pop in flight -> ERROR next cycle, in-flight write suppressed, error=1 stays after err_d0=0; init=1 -> INIT.
- reset_L low mid-ACTIVE (asynchronous, between edges) -> all outputs 0 immediately, state=0.
